// File: rtl/lbp_pkg.sv
// Shared constants, FSM encoding and address helpers for the LBP host.
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int LW = $clog2(IMG_W);
  localparam int RW = AW - LW;
  localparam int INTERIOR_CNT = (IMG_W - 2) * (IMG_H - 2);
  localparam int BORDER_CNT = 2 * IMG_W + 2 * (IMG_H - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SERVE,
    S_FILL,
    S_DONE
  } state_t;

  function automatic logic on_border(input logic [AW-1:0] a);
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    row = a[AW-1:LW];
    col = a[LW-1:0];
    return (row == '0) || (row == RW'(IMG_H - 1)) ||
           (col == '0) || (col == LW'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/lbp_border_gen.sv
// Border address sequencer: row 0, last row, then left/right edge pairs.
module lbp_border_gen
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] idx;
  logic [AW-1:0] k;
  logic [RW-1:0] row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (!en) begin
      idx <= '0;
    end else begin
      idx <= idx + AW'(1);
    end
  end

  always_comb begin
    k = idx - AW'(2 * IMG_W);
    row = k[RW:1] + RW'(1);
    last = (idx == AW'(BORDER_CNT - 1));
    if (idx < AW'(IMG_W)) begin
      addr = idx;
    end else if (idx < AW'(2 * IMG_W)) begin
      addr = AW'((IMG_H - 1) * IMG_W) + (idx - AW'(IMG_W));
    end else begin
      addr = {row, {LW{k[0]}}};
    end
  end

endmodule

// File: rtl/lbp_host.sv
// Host responder: image load, gray read service, result capture, border fill.
module lbp_host
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic [AW-1:0] img_addr,
  output logic          img_we,
  output logic [DW-1:0] img_wdata,
  input  logic [DW-1:0] img_rdata,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic [AW-1:0] res_addr,
  output logic          res_we,
  output logic [DW-1:0] res_wdata,
  output logic [AW-1:0] lbp_count,
  output logic          done,
  output logic          err
);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] load_cnt;
  logic          phase_b;
  logic [DW-1:0] gray_hold;
  logic          prev_valid;
  logic [AW-1:0] last_addr;
  logic          fill_en;
  logic          fill_last;
  logic [AW-1:0] fill_addr;
  logic          serve_wr;
  logic          new_res;
  logic [AW-1:0] cnt_inc;

  lbp_border_gen u_border (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (fill_en),
    .addr   (fill_addr),
    .last   (fill_last)
  );

  assign done = (state == S_DONE);
  assign serve_wr = (state == S_SERVE) && lbp_valid;
  assign new_res = serve_wr &&
                   (!prev_valid || (lbp_addr != last_addr));
  assign cnt_inc = lbp_count + {{(AW-1){1'b0}}, new_res};

  always_comb begin
    state_nx = state;
    load_ready = 1'b0;
    img_we = 1'b0;
    img_addr = '0;
    img_wdata = '0;
    gray_ready = 1'b0;
    gray_data = gray_hold;
    res_we = 1'b0;
    res_addr = '0;
    res_wdata = '0;
    fill_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          img_we = 1'b1;
          img_addr = load_cnt;
          img_wdata = load_data;
          if (load_cnt == AW'(IMG_W * IMG_H - 1)) state_nx = S_SERVE;
        end
      end
      S_SERVE: begin
        if (phase_b) begin
          gray_ready = 1'b1;
          gray_data = img_rdata;
        end else if (gray_req) begin
          img_addr = gray_addr;
        end
        if (lbp_valid) begin
          res_we = 1'b1;
          res_addr = lbp_addr;
          res_wdata = lbp_data;
        end
        if (finish) state_nx = S_FILL;
      end
      S_FILL: begin
        fill_en = 1'b1;
        res_we = 1'b1;
        res_addr = fill_addr;
        if (fill_last) state_nx = S_DONE;
      end
      S_DONE: begin
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      load_cnt <= '0;
      phase_b <= 1'b0;
      gray_hold <= '0;
      prev_valid <= 1'b0;
      last_addr <= '0;
      lbp_count <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && start) load_cnt <= '0;
      else if (img_we) load_cnt <= load_cnt + AW'(1);
      phase_b <= (state == S_SERVE) && !phase_b && gray_req;
      if (gray_ready) gray_hold <= img_rdata;
      prev_valid <= serve_wr;
      if (serve_wr) last_addr <= lbp_addr;
      lbp_count <= cnt_inc;
      // finish-cycle write is already folded into cnt_inc
      if (serve_wr && on_border(lbp_addr)) err <= 1'b1;
      if ((state == S_SERVE) && finish &&
          (cnt_inc != AW'(INTERIOR_CNT))) err <= 1'b1;
      if ((state == S_FILL) && lbp_valid) err <= 1'b1;
    end
  end

endmodule
